// File: rtl/uart_tx_frame.sv
// uart_tx_frame: parametrised UART transmitter.
// Frame: start bit, DATA_BITS data bits LSB first, optional odd/even parity,
// STOP_BITS stop bits, then GUARD_CYCLES idle-high cycles before the next frame.
// Build option: define UART_TX_FIFO_EN to put a FIFO_DEPTH-entry FIFO in front
// of the FSM; without it the block holds a single word at a time.
//
// Handshake: a word is transferred on every rising edge where tx_start and
// tx_ready are both high; in_data_byte is sampled only on that edge. tx_ready
// never depends on tx_start, and a tx_start while tx_ready is low is dropped.
//
// All serial outputs (tx_out, tx_busy, tx_done) are registered decodes of the
// FSM state, so they trail the state register by one cycle. dbg_state exposes
// the current FSM state.
module uart_tx_frame #(
  parameter int CLOCKS_PER_BIT = 5208,
  parameter int DATA_BITS      = 8,
  parameter int PARITY         = 0,
  parameter int STOP_BITS      = 1,
  parameter int GUARD_CYCLES   = 2,
  parameter int FIFO_DEPTH     = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 tx_start,
  input  logic [DATA_BITS-1:0] in_data_byte,
  output logic                 tx_ready,
  output logic                 tx_out,
  output logic                 tx_busy,
  output logic                 tx_done,
  output logic [2:0]           dbg_state
);

  localparam int CW = $clog2(CLOCKS_PER_BIT);
  localparam int SW = $clog2(2 * CLOCKS_PER_BIT);
  localparam int IW = $clog2(DATA_BITS);
  localparam int GW = (GUARD_CYCLES > 1) ? $clog2(GUARD_CYCLES) : 1;

  localparam logic [CW-1:0] BIT_LAST   = CW'(CLOCKS_PER_BIT - 1);
  localparam logic [SW-1:0] STOP_LAST  = SW'(STOP_BITS * CLOCKS_PER_BIT - 1);
  localparam logic [IW-1:0] IDX_LAST   = IW'(DATA_BITS - 1);
  localparam logic [GW-1:0] GUARD_LAST = GW'(GUARD_CYCLES - 1);

  // Reject illegal configurations at elaboration time.
  if (CLOCKS_PER_BIT < 2) begin : g_bad_cpb
    $error("uart_tx_frame: CLOCKS_PER_BIT must be >= 2");
  end
  if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
    $error("uart_tx_frame: DATA_BITS must be 5..9");
  end
  if (PARITY < 0 || PARITY > 2) begin : g_bad_parity
    $error("uart_tx_frame: PARITY must be 0, 1 or 2");
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop_bits
    $error("uart_tx_frame: STOP_BITS must be 1 or 2");
  end
  if (GUARD_CYCLES < 1) begin : g_bad_guard
    $error("uart_tx_frame: GUARD_CYCLES must be >= 1");
  end

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_DATA  = 3'd2,
    S_PAR   = 3'd3,
    S_STOP  = 3'd4,
    S_GUARD = 3'd5
  } state_t;

  state_t state, state_next;

  logic [CW-1:0]        clk_cnt;
  logic [SW-1:0]        stop_cnt;
  logic [IW-1:0]        bit_idx;
  logic [GW-1:0]        guard_cnt;
  logic [DATA_BITS-1:0] shreg;
  logic                 par_bit;
  logic                 line_bit;

  logic                 word_avail;
  logic [DATA_BITS-1:0] word_in;

  logic bit_end, last_bit, stop_end, guard_end;

  assign bit_end   = (clk_cnt == BIT_LAST);
  assign last_bit  = (bit_idx == IDX_LAST);
  assign stop_end  = (stop_cnt == STOP_LAST);
  assign guard_end = (guard_cnt == GUARD_LAST);
  assign dbg_state = state;

`ifdef UART_TX_FIFO_EN
  localparam int AW = $clog2(FIFO_DEPTH);

  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_fifo_depth
    $error("uart_tx_frame: FIFO_DEPTH must be a power of two >= 2");
  end

  logic [DATA_BITS-1:0] fifo_mem [FIFO_DEPTH];
  logic [AW:0]          wr_ptr, rd_ptr;
  logic                 fifo_full, fifo_empty, push, pop;

  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign tx_ready   = !fifo_full;
  assign push       = tx_start && tx_ready;
  assign word_avail = !fifo_empty;
  // The FSM loads the head word on the same edge that pops it.
  assign pop        = (state == S_IDLE) && word_avail;
  assign word_in    = fifo_mem[rd_ptr[AW-1:0]];

  // FIFO pointers; reset empties the queue.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // FIFO storage write port.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr[AW-1:0]] <= in_data_byte;
  end
`else
  // FIFO_DEPTH has no effect without the FIFO.
  if (FIFO_DEPTH < 0) begin : g_fifo_depth_unused
  end

  // Ready only while idle and not on the tx_done cycle (tx_busy still high).
  assign tx_ready   = (state == S_IDLE) && !tx_busy;
  assign word_avail = tx_start && tx_ready;
  assign word_in    = in_data_byte;
`endif

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_next;
  end

  // FSM next-state logic.
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:  if (word_avail) state_next = S_START;
      S_START: if (bit_end) state_next = S_DATA;
      S_DATA:  if (bit_end && last_bit) state_next = (PARITY != 0) ? S_PAR : S_STOP;
      S_PAR:   if (bit_end) state_next = S_STOP;
      S_STOP:  if (stop_end) state_next = S_GUARD;
      S_GUARD: if (guard_end) state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // Bit timing counters, shift register and parity capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      clk_cnt   <= '0;
      stop_cnt  <= '0;
      bit_idx   <= '0;
      guard_cnt <= '0;
      shreg     <= '0;
      par_bit   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          clk_cnt   <= '0;
          stop_cnt  <= '0;
          bit_idx   <= '0;
          guard_cnt <= '0;
          if (word_avail) begin
            shreg   <= word_in;
            // Even parity is the XOR of the data; odd parity is its inverse.
            par_bit <= (^word_in) ^ (PARITY == 1);
          end
        end
        S_START, S_PAR: begin
          clk_cnt <= bit_end ? '0 : clk_cnt + 1'b1;
        end
        S_DATA: begin
          clk_cnt <= bit_end ? '0 : clk_cnt + 1'b1;
          if (bit_end) begin
            shreg   <= shreg >> 1;
            bit_idx <= last_bit ? '0 : bit_idx + 1'b1;
          end
        end
        S_STOP: begin
          stop_cnt <= stop_end ? '0 : stop_cnt + 1'b1;
        end
        S_GUARD: begin
          guard_cnt <= guard_end ? '0 : guard_cnt + 1'b1;
        end
        default: begin
          clk_cnt <= '0;
        end
      endcase
    end
  end

  // Line level implied by the current state.
  always_comb begin
    line_bit = 1'b1;
    case (state)
      S_START: line_bit = 1'b0;
      S_DATA:  line_bit = shreg[0];
      S_PAR:   line_bit = par_bit;
      default: line_bit = 1'b1;
    endcase
  end

  // Registered serial outputs; reset forces the line idle and drops any frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      tx_out  <= 1'b1;
      tx_busy <= 1'b0;
      tx_done <= 1'b0;
    end else begin
      tx_out  <= line_bit;
      tx_busy <= (state != S_IDLE);
      tx_done <= (state == S_GUARD) && guard_end;
    end
  end

endmodule

// File: tb/tb_uart_tx_frame.sv
// tb_uart_tx_frame: bench for uart_tx_frame with four configurations
// (8N1, 8E1, 8O1, 5N2) sharing one clock, CLOCKS_PER_BIT=4, GUARD_CYCLES=2.
// Expected line levels come from a frame model built from the bit layout.
module tb_uart_tx_frame;

  localparam int CPB = 4;
  localparam int GRD = 2;
  localparam int NI  = 4;
`ifdef UART_TX_FIFO_EN
  localparam int FIFO = 1;
`else
  localparam int FIFO = 0;
`endif
  localparam int LAT = (FIFO != 0) ? 2 : 1;

  int cfg_db  [NI] = '{8, 8, 8, 5};
  int cfg_par [NI] = '{0, 2, 1, 0};
  int cfg_sb  [NI] = '{1, 1, 1, 2};

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [NI-1:0] start = '0;
  logic [8:0]    din [NI];
  wire  [NI-1:0] txo, busy, done, rdy;
  wire  [2:0]    dbg [NI];

  int checks = 0;
  int errors = 0;

  // Clock generation.
  always #5 clk = ~clk;

  uart_tx_frame #(.CLOCKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1),
                  .GUARD_CYCLES(GRD), .FIFO_DEPTH(4)) u_8n1 (
    .clk(clk), .rst(rst), .tx_start(start[0]), .in_data_byte(din[0][7:0]),
    .tx_ready(rdy[0]), .tx_out(txo[0]), .tx_busy(busy[0]), .tx_done(done[0]),
    .dbg_state(dbg[0]));

  uart_tx_frame #(.CLOCKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1),
                  .GUARD_CYCLES(GRD), .FIFO_DEPTH(4)) u_8e1 (
    .clk(clk), .rst(rst), .tx_start(start[1]), .in_data_byte(din[1][7:0]),
    .tx_ready(rdy[1]), .tx_out(txo[1]), .tx_busy(busy[1]), .tx_done(done[1]),
    .dbg_state(dbg[1]));

  uart_tx_frame #(.CLOCKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1),
                  .GUARD_CYCLES(GRD), .FIFO_DEPTH(4)) u_8o1 (
    .clk(clk), .rst(rst), .tx_start(start[2]), .in_data_byte(din[2][7:0]),
    .tx_ready(rdy[2]), .tx_out(txo[2]), .tx_busy(busy[2]), .tx_done(done[2]),
    .dbg_state(dbg[2]));

  uart_tx_frame #(.CLOCKS_PER_BIT(CPB), .DATA_BITS(5), .PARITY(0), .STOP_BITS(2),
                  .GUARD_CYCLES(GRD), .FIFO_DEPTH(4)) u_5n2 (
    .clk(clk), .rst(rst), .tx_start(start[3]), .in_data_byte(din[3][4:0]),
    .tx_ready(rdy[3]), .tx_out(txo[3]), .tx_busy(busy[3]), .tx_done(done[3]),
    .dbg_state(dbg[3]));

  // Advance one clock; outputs are sampled 1 time unit after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Frame length from first start-bit cycle to tx_done cycle inclusive.
  function automatic int frame_len(int k);
    return (1 + cfg_db[k] + ((cfg_par[k] != 0) ? 1 : 0) + cfg_sb[k]) * CPB + GRD;
  endfunction

  // Expected line level on cycle i of a frame carrying word w.
  function automatic logic exp_line(int k, logic [8:0] w, int i);
    int   b  = i / CPB;
    int   db = cfg_db[k];
    logic p  = 1'b0;
    if (b == 0) return 1'b0;
    if (b <= db) return w[b-1];
    if (cfg_par[k] != 0 && b == db + 1) begin
      for (int j = 0; j < db; j++) p = p ^ w[j];
      return (cfg_par[k] == 1) ? ~p : p;
    end
    return 1'b1;
  endfunction

  // Check a frame cycle by cycle from cycle first_i; ends on the cycle after tx_done.
  task automatic check_frame(int k, logic [8:0] w, int first_i, int poke,
                             bit hold_next, logic [8:0] w_next, int rdy_exp);
    int len = frame_len(k);
    for (int i = first_i; i < len; i++) begin
      chk($sformatf("u%0d line c%0d", k, i), txo[k], exp_line(k, w, i));
      chk($sformatf("u%0d busy c%0d", k, i), busy[k], 1);
      chk($sformatf("u%0d done c%0d", k, i), done[k], (i == len - 1) ? 1 : 0);
      if (rdy_exp >= 0) chk($sformatf("u%0d ready c%0d", k, i), rdy[k], rdy_exp);
      if (i == poke) begin
        start[k] = 1'b1;
        din[k]   = 9'h03C;
      end else if (i == poke + 1) begin
        start[k] = 1'b0;
      end
      if (hold_next && i == len - 1) begin
        start[k] = 1'b1;
        din[k]   = w_next;
      end
      step();
    end
    chk($sformatf("u%0d idle line", k), txo[k], 1);
    chk($sformatf("u%0d idle busy", k), busy[k], 0);
    chk($sformatf("u%0d idle done", k), done[k], 0);
  endtask

  // Wait (bounded) for ready, hand over one word, check latency and the frame.
  task automatic send_frame(int k, logic [8:0] w, int poke, bit hold_next, logic [8:0] w_next);
    for (int t = 0; t < 300 && rdy[k] !== 1'b1; t++) step();
    chk($sformatf("u%0d ready before send", k), rdy[k], 1);
    start[k] = 1'b1;
    din[k]   = w;
    step();
    start[k] = 1'b0;
    din[k]   = 9'($urandom_range(0, 511));
    for (int j = 0; j < LAT; j++) begin
      chk($sformatf("u%0d latency line %0d", k, j), txo[k], 1);
      chk($sformatf("u%0d latency busy %0d", k, j), busy[k], 0);
      step();
    end
    check_frame(k, w, 0, poke, hold_next, w_next, (FIFO != 0) ? 1 : 0);
    chk($sformatf("u%0d ready after frame", k), rdy[k], 1);
  endtask

  // Watchdog so the run always ends.
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Directed and random stimulus.
  initial begin
    logic [8:0] words [5];
    words = '{9'h011, 9'h022, 9'h033, 9'h044, 9'h055};
    for (int k = 0; k < NI; k++) din[k] = '0;

    rst = 1'b1;
    repeat (3) step();
    rst = 1'b0;
    for (int k = 0; k < NI; k++) begin
      chk($sformatf("u%0d reset tx_out", k), txo[k], 1);
      chk($sformatf("u%0d reset busy", k), busy[k], 0);
      chk($sformatf("u%0d reset done", k), done[k], 0);
      chk($sformatf("u%0d reset ready", k), rdy[k], 1);
    end

    // Directed frames: 8N1 0xA5, 8E1 0xA5, 8O1 0x00, 5N2 0x1F with upper bits set.
    send_frame(0, 9'h0A5, -1, 1'b0, 9'h000);
    send_frame(1, 9'h0A5, -1, 1'b0, 9'h000);
    send_frame(2, 9'h000, -1, 1'b0, 9'h000);
    send_frame(3, 9'h0FF, -1, 1'b0, 9'h000);

    // Random words on every configuration.
    for (int r = 0; r < 6; r++) begin
      for (int k = 0; k < NI; k++) begin
        send_frame(k, 9'($urandom_range(0, 511)), -1, 1'b0, 9'h000);
      end
    end

`ifndef UART_TX_FIFO_EN
    // Mid-frame start is dropped; a start held across tx_done is taken one cycle later.
    send_frame(0, 9'h0C3, 10, 1'b1, 9'h05A);
    send_frame(0, 9'h05A, -1, 1'b0, 9'h000);
    for (int i = 0; i < 10; i++) begin
      chk("u0 quiet line after busy test", txo[0], 1);
      chk("u0 quiet done after busy test", done[0], 0);
      step();
    end
`endif

    // Reset during data bit 3 of an 0xA5 frame.
    for (int t = 0; t < 300 && rdy[0] !== 1'b1; t++) step();
    chk("u0 ready before reset test", rdy[0], 1);
    start[0] = 1'b1;
    din[0]   = 9'h0A5;
    step();
    start[0] = 1'b0;
    for (int j = 0; j < LAT; j++) step();
    for (int i = 0; i < 17; i++) begin
      chk($sformatf("u0 pre-reset line c%0d", i), txo[0], exp_line(0, 9'h0A5, i));
`ifdef UART_TX_FIFO_EN
      if (i == 5) begin
        start[0] = 1'b1;
        din[0]   = 9'h077;
      end else if (i == 6) begin
        start[0] = 1'b0;
      end
`endif
      step();
    end
    chk("u0 data bit3 before reset", txo[0], 0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("u0 line after reset", txo[0], 1);
    chk("u0 busy after reset", busy[0], 0);
    chk("u0 done after reset", done[0], 0);
    chk("u0 ready after reset", rdy[0], 1);
    for (int i = 0; i < 60; i++) begin
      chk("u0 line quiet after reset", txo[0], 1);
      chk("u0 no done after reset", done[0], 0);
      step();
    end
    send_frame(0, 9'($urandom_range(0, 255)), -1, 1'b0, 9'h000);

`ifdef UART_TX_FIFO_EN
    // Burst of five pushes on consecutive cycles into the FIFO.
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("u0 burst ready %0d", i), rdy[0], 1);
      chk($sformatf("u0 burst line %0d", i), txo[0], (i >= 3) ? 0 : 1);
      start[0] = 1'b1;
      din[0]   = words[i];
      step();
    end
    start[0] = 1'b0;
    chk("u0 burst full", rdy[0], 0);
    check_frame(0, words[0], 2, -1, 1'b0, 9'h000, 0);
    chk("u0 ready after first pop", rdy[0], 1);
    for (int w = 1; w < 5; w++) begin
      step();
      check_frame(0, words[w], 0, -1, 1'b0, 9'h000, 1);
    end
    for (int i = 0; i < 20; i++) begin
      chk("u0 quiet after burst", txo[0], 1);
      chk("u0 no done after burst", done[0], 0);
      step();
    end
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
